stack_pc: RTL and testbench

//  Control part of the stack unit: the sequencer that drives the stack datapath (PO) control lines.

---
 rtl/stack_unit_pkg.sv | 42 ++++
 rtl/stack_pc_decode.sv | 57 +++++
 rtl/stack_pc.sv | 159 +++++++++++++++
 tb/tb_stack_pc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack unit control part: op codes, ALU codes,
// sequencer states and control word. PEEK states exist only with STACK_PC_PEEK_EN.
package stack_unit_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_INC  = 3'd1;
    localparam logic [2:0] ALU_DEC  = 3'd2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PUSH_LD  = 4'd1,
        ST_PUSH_WR  = 4'd2,
        ST_PUSH_INC = 4'd3,
        ST_POP_DEC  = 4'd4,
        ST_POP_RD   = 4'd5,
        ST_CLR      = 4'd6,
        ST_RESP     = 4'd7
`ifdef STACK_PC_PEEK_EN
        ,
        ST_PEEK_DEC = 4'd8,
        ST_PEEK_RD  = 4'd9,
        ST_PEEK_INC = 4'd10
`endif
    } state_e;

    typedef struct packed {
        logic       beta_datain;
        logic       alpha_k_mem1;
        logic       beta_mem;
        logic [2:0] alpha_alu2;
        logic       beta_hd;
        logic       beta_dataout;
    } ctrl_t;

endpackage

// File: rtl/stack_pc_decode.sv
// State to control-word decoder for the stack sequencer.
// Purely combinational; every state not listed drives an all-zero word.
module stack_pc_decode
    import stack_unit_pkg::*;
(
    input  state_e i_state,
    output ctrl_t  o_ctrl
);

    // Moore decode: one fixed alpha/beta pattern per micro-step
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_PUSH_LD: begin
                o_ctrl.beta_datain = 1'b1;
            end
            ST_PUSH_WR: begin
                o_ctrl.alpha_k_mem1 = 1'b0;
                o_ctrl.beta_mem     = 1'b1;
            end
            ST_PUSH_INC: begin
                o_ctrl.alpha_alu2 = ALU_INC;
                o_ctrl.beta_hd    = 1'b1;
            end
            ST_POP_DEC: begin
                o_ctrl.alpha_alu2 = ALU_DEC;
                o_ctrl.beta_hd    = 1'b1;
            end
            ST_POP_RD: begin
                o_ctrl.alpha_k_mem1 = 1'b0;
                o_ctrl.beta_dataout = 1'b1;
            end
`ifdef STACK_PC_PEEK_EN
            ST_PEEK_DEC: begin
                o_ctrl.alpha_alu2 = ALU_DEC;
                o_ctrl.beta_hd    = 1'b1;
            end
            ST_PEEK_RD: begin
                o_ctrl.alpha_k_mem1 = 1'b0;
                o_ctrl.beta_dataout = 1'b1;
            end
            ST_PEEK_INC: begin
                o_ctrl.alpha_alu2 = ALU_INC;
                o_ctrl.beta_hd    = 1'b1;
            end
`endif
            ST_CLR: begin
                o_ctrl.alpha_alu2 = ALU_PASS;
                o_ctrl.beta_hd    = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/stack_pc.sv
// Stack unit sequencer: expands host push/pop/peek/clear requests into PO pulses,
// tracks depth, returns results. PEEK support is built only with STACK_PC_PEEK_EN.
module stack_pc
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int NW    = 10,
    parameter int DW    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [1:0]           op_code,
    input  logic [DW-1:0]        op_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DW-1:0]        res_data,
    output logic                 res_err,
    output logic [NW:0]          depth,
    output logic [DW-1:0]        datain,
    output logic                 beta_datain,
    output logic                 alpha_k_mem1,
    output logic                 beta_mem,
    output logic [2:0]           alpha_alu2,
    output logic                 beta_hd,
    output logic                 beta_dataout,
    input  logic signed [DW-1:0] po_out,
    output logic [NW-1:0]        n
);

    localparam logic [NW:0]   LP_FULL = (NW+1)'(DEPTH);
    localparam logic [NW-1:0] LP_N    = NW'(DEPTH - 1);

    state_e        r_state;
    logic [NW:0]   r_depth;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_res_data;
    logic          r_op_ready;
    logic          r_res_valid;
    logic          r_res_err;

    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    state_e        w_next;
    ctrl_t         w_ctrl;

    assign w_accept = op_valid & r_op_ready;
    assign w_full   = (r_depth >= LP_FULL);
    assign w_empty  = (r_depth == '0);

    // Route a new request to its first micro-step, or straight to an error response
    always_comb begin
        w_next = ST_RESP;
        case (op_e'(op_code))
            OP_PUSH: if (!w_full)  w_next = ST_PUSH_LD;
            OP_POP:  if (!w_empty) w_next = ST_POP_DEC;
            OP_PEEK: begin
`ifdef STACK_PC_PEEK_EN
                if (!w_empty) w_next = ST_PEEK_DEC;
`endif
            end
            OP_CLR:  w_next = ST_CLR;
            default: w_next = ST_RESP;
        endcase
    end

    // Sequencer FSM with depth counter and registered handshake/response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_depth     <= '0;
            r_data      <= '0;
            r_res_data  <= '0;
            r_op_ready  <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data     <= op_data;
                        r_op_ready <= 1'b0;
                        r_res_data <= '0;
                        r_res_err  <= 1'b0;
                        r_state    <= w_next;
                        if (w_next == ST_RESP) begin
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                        end
                    end
                end
                ST_PUSH_LD:  r_state <= ST_PUSH_WR;
                ST_PUSH_WR:  r_state <= ST_PUSH_INC;
                ST_PUSH_INC: begin
                    r_depth     <= r_depth + 1'b1;
                    r_state     <= ST_RESP;
                    r_res_valid <= 1'b1;
                end
                ST_POP_DEC: begin
                    r_depth <= r_depth - 1'b1;
                    r_state <= ST_POP_RD;
                end
                ST_POP_RD: begin
                    r_res_data  <= po_out;
                    r_state     <= ST_RESP;
                    r_res_valid <= 1'b1;
                end
`ifdef STACK_PC_PEEK_EN
                ST_PEEK_DEC: r_state <= ST_PEEK_RD;
                ST_PEEK_RD:  r_state <= ST_PEEK_INC;
                ST_PEEK_INC: begin
                    r_res_data  <= po_out;
                    r_state     <= ST_RESP;
                    r_res_valid <= 1'b1;
                end
`endif
                ST_CLR: begin
                    r_depth     <= '0;
                    r_state     <= ST_RESP;
                    r_res_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_op_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res_valid <= 1'b0;
                    r_op_ready  <= 1'b1;
                end
            endcase
        end
    end

    stack_pc_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    assign op_ready     = r_op_ready;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_err      = r_res_err;
    assign depth        = r_depth;
    assign datain       = (r_state == ST_PUSH_LD) ? r_data : '0;
    assign beta_datain  = w_ctrl.beta_datain;
    assign alpha_k_mem1 = w_ctrl.alpha_k_mem1;
    assign beta_mem     = w_ctrl.beta_mem;
    assign alpha_alu2   = w_ctrl.alpha_alu2;
    assign beta_hd      = w_ctrl.beta_hd;
    assign beta_dataout = w_ctrl.beta_dataout;
    assign n            = LP_N;

endmodule

// File: tb/tb_stack_pc.sv
// Bench for stack_pc: PO model, stack-level reference model with per-cycle compare,
// plus directed operations with literal expectations. Honours STACK_PC_PEEK_EN.
module tb_stack_pc;
    import stack_unit_pkg::*;

    localparam int DEPTH = 4;
    localparam int NW    = 2;
    localparam int DW    = 32;
`ifdef STACK_PC_PEEK_EN
    localparam bit PEEK_ON = 1'b1;
`else
    localparam bit PEEK_ON = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 op_valid = 1'b0;
    logic                 op_ready;
    logic [1:0]           op_code = 2'b00;
    logic [DW-1:0]        op_data = '0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [DW-1:0]        res_data;
    logic                 res_err;
    logic [NW:0]          depth;
    logic [DW-1:0]        datain;
    logic                 beta_datain;
    logic                 alpha_k_mem1;
    logic                 beta_mem;
    logic [2:0]           alpha_alu2;
    logic                 beta_hd;
    logic                 beta_dataout;
    logic signed [DW-1:0] po_out;
    logic [NW-1:0]        n;

    stack_pc #(.DEPTH(DEPTH), .NW(NW), .DW(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .op_data      (op_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_err      (res_err),
        .depth        (depth),
        .datain       (datain),
        .beta_datain  (beta_datain),
        .alpha_k_mem1 (alpha_k_mem1),
        .beta_mem     (beta_mem),
        .alpha_alu2   (alpha_alu2),
        .beta_hd      (beta_hd),
        .beta_dataout (beta_dataout),
        .po_out       (po_out),
        .n            (n)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // PO datapath model: input reg, memory addressed by HD, HD register with ALU
    logic [DW-1:0] po_mem [0:7];
    logic [2:0]    po_hd;
    logic [DW-1:0] po_din;
    initial for (int i = 0; i < 8; i++) po_mem[i] = '0;
    always @(posedge clock) begin
        if (reset) begin
            po_hd <= '0;
        end else begin
            if (beta_datain) po_din <= datain;
            if (beta_mem) po_mem[po_hd] <= po_din;
            if (beta_hd) begin
                case (alpha_alu2)
                    ALU_PASS: po_hd <= datain[2:0];
                    ALU_INC:  po_hd <= po_hd + 3'd1;
                    ALU_DEC:  po_hd <= po_hd - 3'd1;
                    default:  po_hd <= po_hd;
                endcase
            end
        end
    end
    assign po_out = po_mem[po_hd];

    // Reference model: abstract stack plus the expected pulse list per request
    typedef struct {
        logic [3:0]    b;
        logic [2:0]    alu;
        logic          dchk;
        logic [DW-1:0] din;
    } step_t;

    step_t         m_steps[$];
    logic [DW-1:0] m_stack[$];
    int            m_mode = 0;
    logic [DW-1:0] m_rdata;
    logic          m_rerr;

    function automatic step_t mk(logic [3:0] b, logic [2:0] alu, logic dchk, logic [DW-1:0] din);
        step_t s;
        s.b = b;
        s.alu = alu;
        s.dchk = dchk;
        s.din = din;
        return s;
    endfunction

    always @(negedge clock) begin
        step_t s;
        if (reset) begin
            m_mode = 0;
            m_steps.delete();
            m_stack.delete();
        end else begin
            case (m_mode)
                0: begin
                    check("idle_op_ready", op_ready, 1);
                    check("idle_res_valid", res_valid, 0);
                    check("idle_betas", {beta_datain, beta_mem, beta_hd, beta_dataout}, 0);
                    check("idle_depth", depth, m_stack.size());
                    if (op_valid) begin
                        m_rerr = 1'b0;
                        m_rdata = '0;
                        m_steps.delete();
                        case (op_code)
                            OP_PUSH: begin
                                if (m_stack.size() < DEPTH) begin
                                    m_steps.push_back(mk(4'b1000, ALU_PASS, 1'b1, op_data));
                                    m_steps.push_back(mk(4'b0100, ALU_PASS, 1'b0, '0));
                                    m_steps.push_back(mk(4'b0010, ALU_INC, 1'b0, '0));
                                    m_stack.push_back(op_data);
                                end else m_rerr = 1'b1;
                            end
                            OP_POP: begin
                                if (m_stack.size() > 0) begin
                                    m_steps.push_back(mk(4'b0010, ALU_DEC, 1'b0, '0));
                                    m_steps.push_back(mk(4'b0001, ALU_PASS, 1'b0, '0));
                                    m_rdata = m_stack.pop_back();
                                end else m_rerr = 1'b1;
                            end
                            OP_PEEK: begin
                                if (PEEK_ON && m_stack.size() > 0) begin
                                    m_steps.push_back(mk(4'b0010, ALU_DEC, 1'b0, '0));
                                    m_steps.push_back(mk(4'b0001, ALU_PASS, 1'b0, '0));
                                    m_steps.push_back(mk(4'b0010, ALU_INC, 1'b0, '0));
                                    m_rdata = m_stack[$];
                                end else m_rerr = 1'b1;
                            end
                            default: begin
                                m_steps.push_back(mk(4'b0010, ALU_PASS, 1'b1, '0));
                                m_stack.delete();
                            end
                        endcase
                        m_mode = (m_steps.size() != 0) ? 1 : 2;
                    end
                end
                1: begin
                    s = m_steps.pop_front();
                    check("step_betas", {beta_datain, beta_mem, beta_hd, beta_dataout}, s.b);
                    if (s.b[1]) check("step_alu", alpha_alu2, s.alu);
                    if (s.b[2] | s.b[0]) check("step_kmem", alpha_k_mem1, 0);
                    if (s.dchk) check("step_datain", datain, s.din);
                    check("busy_op_ready", op_ready, 0);
                    check("busy_res_valid", res_valid, 0);
                    if (m_steps.size() == 0) m_mode = 2;
                end
                default: begin
                    check("resp_valid", res_valid, 1);
                    check("resp_op_ready", op_ready, 0);
                    check("resp_data", res_data, m_rdata);
                    check("resp_err", res_err, m_rerr);
                    check("resp_depth", depth, m_stack.size());
                    check("resp_betas", {beta_datain, beta_mem, beta_hd, beta_dataout}, 0);
                    if (res_ready) m_mode = 0;
                end
            endcase
        end
    end

    task automatic do_op(input logic [1:0] code, input logic [DW-1:0] data, input int hold,
                         output logic [DW-1:0] rd, output logic re, output int lat);
        int w;
        op_code = code;
        op_data = data;
        op_valid = 1'b1;
        w = 0;
        while (!op_ready && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        check("accept_bound", op_ready, 1);
        @(posedge clock); #1;
        op_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        check("resp_bound", res_valid, 1);
        repeat (hold) begin
            op_valid = 1'b1;
            op_code = OP_PUSH;
            op_data = 32'hdead;
            @(posedge clock); #1;
        end
        op_valid = 1'b0;
        rd = res_data;
        re = res_err;
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          re;
        int            lat;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_datain", datain, 0);
        check("rst_depth", depth, 0);
        check("rst_op_ready", op_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("n_const", n, DEPTH - 1);
        @(posedge clock); #1;

        do_op(OP_PUSH, 32'd10, 0, rd, re, lat);
        check("push10_lat", lat, 4);
        check("push10_err", re, 0);
        do_op(OP_PUSH, 32'd20, 0, rd, re, lat);
        check("push20_lat", lat, 4);
        check("t1_depth", depth, 2);

        do_op(OP_POP, '0, 0, rd, re, lat);
        check("pop1_data", rd, 20);
        check("pop1_lat", lat, 3);
        do_op(OP_POP, '0, 0, rd, re, lat);
        check("pop2_data", rd, 10);
        check("t2_depth", depth, 0);
        do_op(OP_POP, '0, 0, rd, re, lat);
        check("pop_empty_err", re, 1);
        check("pop_empty_lat", lat, 1);
        check("pop_empty_data", rd, 0);

        for (int i = 1; i <= DEPTH; i++) do_op(OP_PUSH, 32'(i), 0, rd, re, lat);
        check("t3_full_depth", depth, 4);
        do_op(OP_PUSH, 32'd99, 0, rd, re, lat);
        check("push_full_err", re, 1);
        check("push_full_lat", lat, 1);
        check("t3_depth_kept", depth, 4);

        do_op(OP_POP, '0, 5, rd, re, lat);
        check("hold_pop_data", rd, 4);
        check("t4_depth", depth, 3);

        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        check("stray_ready_valid", res_valid, 0);
        check("stray_ready_op_ready", op_ready, 1);

        do_op(OP_CLR, '0, 0, rd, re, lat);
        check("clr_lat", lat, 2);
        check("clr_depth", depth, 0);

        op_code = OP_PUSH;
        op_data = 32'd7;
        op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        @(posedge clock); #1;
        check("t5_in_wr", beta_mem, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t5_betas", {beta_datain, beta_mem, beta_hd, beta_dataout}, 0);
        check("t5_depth", depth, 0);
        check("t5_op_ready", op_ready, 1);
        @(posedge clock); #1;
        check("t5_no_pulse", {beta_datain, beta_mem, beta_hd, beta_dataout}, 0);

        do_op(OP_PUSH, 32'd5, 0, rd, re, lat);
        do_op(OP_PUSH, 32'd6, 0, rd, re, lat);
        do_op(OP_PEEK, '0, 0, rd, re, lat);
        check("peek_data", rd, PEEK_ON ? 32'd6 : 32'd0);
        check("peek_err", re, PEEK_ON ? 1'b0 : 1'b1);
        check("peek_lat", lat, PEEK_ON ? 4 : 1);
        check("peek_depth", depth, 2);
        do_op(OP_POP, '0, 0, rd, re, lat);
        check("after_peek_pop", rd, 6);
        do_op(OP_POP, '0, 0, rd, re, lat);
        check("after_peek_pop2", rd, 5);
        do_op(OP_PEEK, '0, 0, rd, re, lat);
        check("peek_empty_err", re, 1);
        check("peek_empty_lat", lat, 1);

        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
